ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 35 +++
 rtl/ram_arbiter_if.sv | 55 +++++
 rtl/fifo.sv | 54 +++++
 rtl/ram_arbiter.sv | 123 ++++++++++++
 tb/tb_ram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and widths for the two-port RAM arbiter.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package ram_arbiter_pkg;

    localparam int ADDR_W     = 15;   // requester 32-bit word address
    localparam int DATA_W     = 32;   // requester data width
    localparam int BE_W       = 4;    // requester byte lanes
    localparam int AVL_ADDR_W = 14;   // 64-bit word address on the RAM side
    localparam int AVL_DATA_W = 64;
    localparam int AVL_BE_W   = 8;
    localparam int TAG_W      = 2;

    localparam logic PORT_0 = 1'b0;
    localparam logic PORT_1 = 1'b1;

    // Read-return tag: which port asked, and which 32-bit half of the 64-bit word it wants.
    typedef struct packed {
        logic port_id;
        logic addr0;
    } tag_t;

    // Place a 32-bit store into the lane selected by the low address bit; other lane is zero.
    function automatic logic [AVL_DATA_W-1:0] place_lane(input logic [DATA_W-1:0] d,
                                                         input logic lane);
        return lane ? {d, {DATA_W{1'b0}}} : {{DATA_W{1'b0}}, d};
    endfunction

    // Byte enables follow the data into the selected lane.
    function automatic logic [AVL_BE_W-1:0] place_be(input logic [BE_W-1:0] be,
                                                     input logic lane);
        return lane ? {be, {BE_W{1'b0}}} : {{BE_W{1'b0}}, be};
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of both requester ports plus the 64-bit RAM-side bus.
// Latency: n/a (wiring only).
// Backpressure: pX_ready / avl_ready carry the stall; modport slave is the arbiter, master the environment.
interface ram_arbiter_if;
    import ram_arbiter_pkg::*;

    // requester port 0
    logic                  p0_ready;
    logic [ADDR_W-1:0]     p0_addr;
    logic [DATA_W-1:0]     p0_write_data;
    logic [BE_W-1:0]       p0_byte_enable;
    logic                  p0_write_req;
    logic                  p0_read_req;
    logic [DATA_W-1:0]     p0_read_data;
    logic                  p0_read_data_valid;

    // requester port 1
    logic                  p1_ready;
    logic [ADDR_W-1:0]     p1_addr;
    logic [DATA_W-1:0]     p1_write_data;
    logic [BE_W-1:0]       p1_byte_enable;
    logic                  p1_write_req;
    logic                  p1_read_req;
    logic [DATA_W-1:0]     p1_read_data;
    logic                  p1_read_data_valid;

    // RAM side
    logic                  avl_ready;
    logic [AVL_ADDR_W-1:0] avl_addr;
    logic [AVL_DATA_W-1:0] avl_wdata;
    logic [AVL_BE_W-1:0]   avl_be;
    logic                  avl_read_req;
    logic                  avl_write_req;
    logic [AVL_DATA_W-1:0] avl_rdata;
    logic                  avl_rdata_valid;

    modport slave (
        output p0_ready, p0_read_data, p0_read_data_valid,
        input  p0_addr, p0_write_data, p0_byte_enable, p0_write_req, p0_read_req,
        output p1_ready, p1_read_data, p1_read_data_valid,
        input  p1_addr, p1_write_data, p1_byte_enable, p1_write_req, p1_read_req,
        input  avl_ready, avl_rdata, avl_rdata_valid,
        output avl_addr, avl_wdata, avl_be, avl_read_req, avl_write_req
    );

    modport master (
        input  p0_ready, p0_read_data, p0_read_data_valid,
        output p0_addr, p0_write_data, p0_byte_enable, p0_write_req, p0_read_req,
        input  p1_ready, p1_read_data, p1_read_data_valid,
        output p1_addr, p1_write_data, p1_byte_enable, p1_write_req, p1_read_req,
        output avl_ready, avl_rdata, avl_rdata_valid,
        input  avl_addr, avl_wdata, avl_be, avl_read_req, avl_write_req
    );

endinterface

// File: rtl/fifo.sv
// Generic synchronous FIFO, show-ahead head (pop_dat valid whenever !empty).
// Latency: one cycle from push to visibility at the head.
// Backpressure: push ignored while full, pop ignored while empty; caller gates on full/empty.
// Ports: core_clk, arst_n, push_vld/push_dat/full, pop_vld/pop_dat/empty.
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_BITS = 4
) (
    input  logic                  core_clk,
    input  logic                  arst_n,
    input  logic                  push_vld,
    input  logic [DATA_WIDTH-1:0] push_dat,
    output logic                  full,
    input  logic                  pop_vld,
    output logic [DATA_WIDTH-1:0] pop_dat,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [DEPTH_BITS:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS:0]   rd_ptr_q, rd_ptr_d;
    logic                  do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) &&
                     (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);
    assign do_push = push_vld && !full;
    assign do_pop  = pop_vld && !empty;

    assign wr_ptr_d = wr_ptr_q + (DEPTH_BITS+1)'(do_push);
    assign rd_ptr_d = rd_ptr_q + (DEPTH_BITS+1)'(do_pop);
    assign pop_dat  = mem_q[rd_ptr_q[DEPTH_BITS-1:0]];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge core_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[DEPTH_BITS-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port 32-bit requester arbiter onto a 64-bit RAM bus, with in-order read-return routing.
// Latency: zero -- the granted command drives avl_* in the same cycle; returns route combinationally.
// Backpressure: grant only when avl_ready=1 and the tag FIFO has room; loser holds until its ready=1.
// Ports: clk, reset_n (async active-low), bus (ram_arbiter_if.slave: p0_*/p1_* requesters, avl_* RAM).
// Build option: RAM_ARBITER_ROUND_ROBIN_EN selects round-robin; otherwise port 0 has fixed priority.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int TAG_DEPTH_BITS = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    ram_arbiter_if.slave  bus
);

    logic              tag_full, tag_empty;
    logic              tag_push, tag_pop;
    tag_t              push_tag, head_tag;

    logic              can_grant;
    logic              p0_req, p1_req;
    logic              pref_port;
    logic              win_port;
    logic              grant_vld;

    logic              sel_rd, sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] ret_dat;

    // reset_n gates everything combinational so outputs fall to zero the moment reset asserts.
    assign can_grant = reset_n && bus.avl_ready && !tag_full;
    assign p0_req    = bus.p0_read_req || bus.p0_write_req;
    assign p1_req    = bus.p1_read_req || bus.p1_write_req;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    // Reset value PORT_1 makes port 0 the first winner.
    assign pref_port    = ~last_grant_q;
    assign last_grant_d = grant_vld ? win_port : last_grant_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= PORT_1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign pref_port = PORT_0;
`endif

    // A lone requester wins outright; contention or idle falls back to the preferred port,
    // so an idle cycle still advertises ready on the port that would win.
    always_comb begin
        win_port = pref_port;
        if (p0_req && !p1_req) begin
            win_port = PORT_0;
        end else if (p1_req && !p0_req) begin
            win_port = PORT_1;
        end
    end

    always_comb begin
        if (win_port == PORT_1) begin
            sel_rd    = bus.p1_read_req;
            sel_wr    = bus.p1_write_req;
            sel_addr  = bus.p1_addr;
            sel_wdata = bus.p1_write_data;
            sel_be    = bus.p1_byte_enable;
        end else begin
            sel_rd    = bus.p0_read_req;
            sel_wr    = bus.p0_write_req;
            sel_addr  = bus.p0_addr;
            sel_wdata = bus.p0_write_data;
            sel_be    = bus.p0_byte_enable;
        end
    end

    assign grant_vld = can_grant && (sel_rd || sel_wr);

    assign bus.p0_ready = can_grant && (win_port == PORT_0);
    assign bus.p1_ready = can_grant && (win_port == PORT_1);

    // Bit 0 of the 32-bit word address picks the lane; the rest is the 64-bit word address.
    assign bus.avl_read_req  = grant_vld && sel_rd;
    assign bus.avl_write_req = grant_vld && sel_wr;
    assign bus.avl_addr      = grant_vld ? sel_addr[ADDR_W-1:1] : '0;
    assign bus.avl_wdata     = grant_vld ? place_lane(sel_wdata, sel_addr[0]) : '0;
    assign bus.avl_be        = grant_vld ? place_be(sel_be, sel_addr[0]) : '0;

    // Only reads need a return path, so only they consume a tag.
    assign tag_push         = grant_vld && sel_rd;
    assign push_tag.port_id = win_port;
    assign push_tag.addr0   = sel_addr[0];

    // A return with no outstanding tag is dropped: nothing to route it to.
    assign tag_pop = reset_n && bus.avl_rdata_valid && !tag_empty;
    assign ret_dat = head_tag.addr0 ? bus.avl_rdata[AVL_DATA_W-1:DATA_W]
                                    : bus.avl_rdata[DATA_W-1:0];

    assign bus.p0_read_data_valid = tag_pop && (head_tag.port_id == PORT_0);
    assign bus.p1_read_data_valid = tag_pop && (head_tag.port_id == PORT_1);
    assign bus.p0_read_data       = bus.p0_read_data_valid ? ret_dat : '0;
    assign bus.p1_read_data       = bus.p1_read_data_valid ? ret_dat : '0;

    fifo #(
        .DATA_WIDTH (TAG_W),
        .DEPTH_BITS (TAG_DEPTH_BITS)
    ) u_tag_fifo (
        .core_clk (clk),
        .arst_n   (reset_n),
        .push_vld (tag_push),
        .push_dat (push_tag),
        .full     (tag_full),
        .pop_vld  (tag_pop),
        .pop_dat  (head_tag),
        .empty    (tag_empty)
    );

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int TDB   = 4;
    localparam int DEPTH = 1 << TDB;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_if bus ();

    ram_arbiter #(.TAG_DEPTH_BITS(TDB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: outstanding reads as {port, lane} in issue order, plus last granted port.
    logic [1:0] tagq [$];
    logic       last_grant = 1'b1;
    bit         g0, g1;
    int         grant_log [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit pref_port();
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        return !last_grant;
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input int p, input bit rd, input bit wr, input logic [14:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (p == 0) begin
            bus.p0_read_req = rd;  bus.p0_write_req = wr;  bus.p0_addr = a;
            bus.p0_write_data = d; bus.p0_byte_enable = be;
        end else begin
            bus.p1_read_req = rd;  bus.p1_write_req = wr;  bus.p1_addr = a;
            bus.p1_write_data = d; bus.p1_byte_enable = be;
        end
    endtask

    task automatic idle_all();
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        bus.avl_ready       = 1'b1;
        bus.avl_rdata_valid = 1'b0;
        bus.avl_rdata       = '0;
    endtask

    task automatic model_reset();
        tagq.delete();
        last_grant = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".p0_ready"}, bus.p0_ready, 0);
        chk({tag, ".p1_ready"}, bus.p1_ready, 0);
        chk({tag, ".p0_valid"}, bus.p0_read_data_valid, 0);
        chk({tag, ".p1_valid"}, bus.p1_read_data_valid, 0);
        chk({tag, ".p0_rdata"}, bus.p0_read_data, 0);
        chk({tag, ".p1_rdata"}, bus.p1_read_data, 0);
        chk({tag, ".avl_rd"}, bus.avl_read_req, 0);
        chk({tag, ".avl_wr"}, bus.avl_write_req, 0);
    endtask

    // Called at a falling edge with inputs already applied; checks every output against the
    // model, commits the rising edge's effect to the model, and returns at the next falling edge.
    task automatic step(input string tag);
        bit          r0, r1, can, who, gnt, rd, wr, rv0, rv1;
        logic [14:0] a;
        logic [31:0] d, rexp;
        logic [3:0]  be;
        logic [1:0]  t;
        logic [63:0] ret;
        #1;
        r0  = bus.p0_read_req || bus.p0_write_req;
        r1  = bus.p1_read_req || bus.p1_write_req;
        can = bus.avl_ready && (tagq.size() < DEPTH);
        if (r0 && r1)  who = pref_port();
        else if (r0)   who = 1'b0;
        else if (r1)   who = 1'b1;
        else           who = pref_port();
        rd  = who ? bus.p1_read_req  : bus.p0_read_req;
        wr  = who ? bus.p1_write_req : bus.p0_write_req;
        a   = who ? bus.p1_addr       : bus.p0_addr;
        d   = who ? bus.p1_write_data : bus.p0_write_data;
        be  = who ? bus.p1_byte_enable : bus.p0_byte_enable;
        gnt = can && (rd || wr);

        chk({tag, ".p0_ready"}, bus.p0_ready, can && !who);
        chk({tag, ".p1_ready"}, bus.p1_ready, can && who);
        chk({tag, ".avl_rd"}, bus.avl_read_req, gnt && rd);
        chk({tag, ".avl_wr"}, bus.avl_write_req, gnt && wr);
        if (gnt) begin
            chk({tag, ".avl_addr"}, bus.avl_addr, a >> 1);
            chk({tag, ".avl_wdata"}, bus.avl_wdata, {32'b0, d} << (a[0] ? 32 : 0));
            chk({tag, ".avl_be"}, bus.avl_be, {4'b0, be} << (a[0] ? 4 : 0));
        end

        rv0 = 1'b0; rv1 = 1'b0; rexp = '0;
        if (bus.avl_rdata_valid) begin
            if (tagq.size() == 0) begin
                $display("note: %s: read return with nothing outstanding (illegal); must be dropped", tag);
            end else begin
                t    = tagq[0];
                ret  = bus.avl_rdata >> (t[0] ? 32 : 0);
                rexp = ret[31:0];
                if (t[1]) rv1 = 1'b1; else rv0 = 1'b1;
            end
        end
        chk({tag, ".p0_valid"}, bus.p0_read_data_valid, rv0);
        chk({tag, ".p1_valid"}, bus.p1_read_data_valid, rv1);
        chk({tag, ".p0_rdata"}, bus.p0_read_data, rv0 ? rexp : 32'h0);
        chk({tag, ".p1_rdata"}, bus.p1_read_data, rv1 ? rexp : 32'h0);

        if (rv0 || rv1) void'(tagq.pop_front());
        if (gnt && rd) tagq.push_back({who, a[0]});
        if (gnt) last_grant = who;
        g0 = gnt && !who;
        g1 = gnt && who;
        @(negedge clk);
    endtask

    initial begin
        logic [14:0] a0, a1;
        bit          pend0, pend1, w;
        int          exp_who;

        // Reset held with traffic present: all outputs must stay quiet.
        idle_all();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        drive(0, 1, 0, 15'h0010, '0, '0);
        drive(1, 0, 1, 15'h0011, 32'h1234, 4'hF);
        bus.avl_rdata_valid = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk);
        idle_all();
        reset_n = 1'b1;
        model_reset();

        // Single read from port 0, upper lane.
        drive(0, 1, 0, 15'h0003, '0, '0);
        #1;
        chk("r027_avl_addr", bus.avl_addr, 14'h0001);
        chk("r027_avl_rd", bus.avl_read_req, 1);
        step("r027_issue");
        idle_all();
        bus.avl_rdata_valid = 1'b1;
        bus.avl_rdata       = 64'h11112222_33334444;
        #1;
        chk("r027_p0_rdata", bus.p0_read_data, 32'h11112222);
        chk("r027_p0_valid", bus.p0_read_data_valid, 1);
        chk("r027_p1_valid", bus.p1_read_data_valid, 0);
        step("r027_return");
        idle_all();
        #1 chk("r027_valid_one_cycle", bus.p0_read_data_valid, 0);
        step("r027_after");

        // Port 1 write to the upper lane; no tag must be pushed.
        drive(1, 0, 1, 15'h0001, 32'hDEADBEEF, 4'h3);
        #1;
        chk("r029_wdata", bus.avl_wdata, 64'hDEADBEEF_00000000);
        chk("r029_be", bus.avl_be, 8'h30);
        chk("r029_wr", bus.avl_write_req, 1);
        step("r029_write");
        idle_all();
        bus.avl_rdata_valid = 1'b1;
        bus.avl_rdata       = {$urandom, $urandom};
        #1;
        chk("r029_no_tag_p0", bus.p0_read_data_valid, 0);
        chk("r029_no_tag_p1", bus.p1_read_data_valid, 0);
        step("r019_stray");
        idle_all();

        // Both ports read every cycle; loser holds its command.
        grant_log.delete();
        a0 = 15'h0100;
        a1 = 15'h0201;
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, a0, '0, '0);
            drive(1, 1, 0, a1, '0, '0);
            step("r028_issue");
            if (g0) a0++;
            if (g1) a1++;
            grant_log.push_back(g1 ? 1 : (g0 ? 0 : -1));
        end
        for (int i = 0; i < 8; i++) begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
            exp_who = i % 2;
`else
            exp_who = 0;
`endif
            chk("r028_grant_order", 64'(grant_log[i]), 64'(exp_who));
        end
        idle_all();
        for (int i = 0; i < 8; i++) begin
            bus.avl_rdata_valid = 1'b1;
            bus.avl_rdata       = {$urandom, $urandom};
            step("r028_return");
        end
        idle_all();
        step("r028_drained");

        // Fill the tag FIFO, then exercise full with a simultaneous pop.
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, 0, 15'(i), '0, '0);
            step("r030_fill");
        end
        drive(0, 1, 0, 15'h7FFF, '0, '0);
        #1;
        chk("r030_full_p0_ready", bus.p0_ready, 0);
        chk("r030_full_p1_ready", bus.p1_ready, 0);
        step("r030_full");
        bus.avl_rdata_valid = 1'b1;
        bus.avl_rdata       = {$urandom, $urandom};
        #1 chk("r030_pop_cycle_ready", bus.p0_ready, 0);
        step("r030_pop_and_req");
        bus.avl_rdata_valid = 1'b0;
        #1 chk("r030_next_cycle_ready", bus.p0_ready, 1);
        step("r030_after_pop");
        idle_all();
        for (int i = 0; i < DEPTH; i++) begin
            bus.avl_rdata_valid = 1'b1;
            bus.avl_rdata       = {$urandom, $urandom};
            step("r030_drain");
        end
        idle_all();

        // RAM stall with both requesting.
        bus.avl_ready = 1'b0;
        drive(0, 1, 0, 15'h0042, '0, '0);
        drive(1, 0, 1, 15'h0043, 32'hCAFEF00D, 4'hF);
        #1;
        chk("r031_stall_rd", bus.avl_read_req, 0);
        chk("r031_stall_wr", bus.avl_write_req, 0);
        chk("r031_stall_rdy0", bus.p0_ready, 0);
        chk("r031_stall_rdy1", bus.p1_ready, 0);
        step("r031_stall");
        idle_all();

        // Three reads outstanding, then reset mid-cycle.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 15'(16 + i), '0, '0);
            step("r031_prefill");
        end
        drive(0, 1, 0, 15'h0050, '0, '0);
        drive(1, 1, 0, 15'h0051, '0, '0);
        bus.avl_rdata_valid = 1'b1;
        bus.avl_rdata       = {$urandom, $urandom};
        #2;
        reset_n = 1'b0;
        #1 check_all_zero("r031_async_reset");
        model_reset();
        @(negedge clk);
        idle_all();
        reset_n = 1'b1;
        bus.avl_rdata_valid = 1'b1;
        bus.avl_rdata       = {$urandom, $urandom};
        #1;
        chk("r022_stale_p0", bus.p0_read_data_valid, 0);
        chk("r022_stale_p1", bus.p1_read_data_valid, 0);
        step("r022_stale_return");
        idle_all();

        // Random traffic: requesters hold commands until granted.
        pend0 = 1'b0;
        pend1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!pend0) begin
                if ($urandom_range(0, 9) < 6) begin
                    w = 1'($urandom_range(0, 1));
                    drive(0, !w, w, 15'($urandom), $urandom, 4'($urandom));
                    pend0 = 1'b1;
                end else begin
                    drive(0, 0, 0, '0, '0, '0);
                end
            end
            if (!pend1) begin
                if ($urandom_range(0, 9) < 6) begin
                    w = 1'($urandom_range(0, 1));
                    drive(1, !w, w, 15'($urandom), $urandom, 4'($urandom));
                    pend1 = 1'b1;
                end else begin
                    drive(1, 0, 0, '0, '0, '0);
                end
            end
            bus.avl_ready = ($urandom_range(0, 9) < 8);
            if (tagq.size() > 0) bus.avl_rdata_valid = ($urandom_range(0, 9) < 4);
            else                 bus.avl_rdata_valid = ($urandom_range(0, 49) == 0);
            bus.avl_rdata = {$urandom, $urandom};
            step("rand");
            if (g0) pend0 = 1'b0;
            if (g1) pend1 = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
